// File: rtl/coherence_bus_pkg.sv
// Shared bus types for the two-cpu snooping coherence bus: op codes,
// FSM state encoding and cpu_datasel codes.
package common;

  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_RD   = 2'b01,
    OP_WR   = 2'b10,
    OP_INV  = 2'b11
  } bus_op_t;

  typedef logic [2:0] bus_state_t;

  localparam bus_state_t ST_IDLE  = 3'd0;
  localparam bus_state_t ST_SNOOP = 3'd1;
  localparam bus_state_t ST_RESP  = 3'd2;
  localparam bus_state_t ST_MEM   = 3'd3;
  localparam bus_state_t ST_DONE  = 3'd4;

  localparam logic [1:0] DSEL_NONE  = 2'b00;
  localparam logic [1:0] DSEL_OTHER = 2'b01;
  localparam logic [1:0] DSEL_MEM   = 2'b10;

  // A cpu may raise several miss lines at once; write dominates invalidate dominates read.
  function automatic bus_op_t pick_op(input logic rd, input logic wr, input logic inv);
    if (wr)       return OP_WR;
    else if (inv) return OP_INV;
    else if (rd)  return OP_RD;
    else          return OP_NONE;
  endfunction

endpackage

// File: rtl/coherence_bus_rr_arb2.sv
// Two-way round-robin arbiter; the preference flips to the other cpu
// whenever update is pulsed with a grant.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] gnt
);

  logic prio1;  // 1: cpu1 wins a tie

  always_comb begin
    gnt = req;
    if (req[0] && req[1]) gnt = prio1 ? 2'b10 : 2'b01;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                prio1 <= 1'b0;
    else if (update && |gnt)   prio1 <= gnt[0];
  end

endmodule

// File: rtl/coherence_bus.sv
// Snooping bus controller between two cpu caches and unified memory.
// Handshake: a cpu holds its request until grant and drops it the cycle after.
module coherence_bus
  import common::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rd_miss0,
  input  logic        rd_miss1,
  input  logic        wr_miss0,
  input  logic        wr_miss1,
  input  logic        inv0,
  input  logic        inv1,
  input  logic [10:0] bico0,
  input  logic [10:0] bico1,
  input  logic        found0,
  input  logic        found1,
  input  logic [15:0] pdata0,
  input  logic [15:0] pdata1,
  input  logic        mem_rdy,
  output logic [12:0] boci,
  output logic        search0,
  output logic        search1,
  output logic        inv_out0,
  output logic        inv_out1,
  output logic        grant0,
  output logic        grant1,
  output logic [1:0]  datasel0,
  output logic [1:0]  datasel1,
  output logic [15:0] odata0,
  output logic [15:0] odata1,
  output logic        mem_re,
  output logic        busy,
  output logic [2:0]  state_dbg
);

  bus_state_t  state;
  logic        cur;  // requester being served: 0 = cpu0, 1 = cpu1
  bus_op_t     op;
  logic [10:0] addr;
  logic [15:0] data;
  logic [1:0]  dsel;

  logic        req0, req1;
  logic [1:0]  arb_req, arb_gnt;
  logic        other_found;
  logic [15:0] other_data;
  logic        snoop, done, kill;

  assign req0 = rd_miss0 | wr_miss0 | inv0;
  assign req1 = rd_miss1 | wr_miss1 | inv1;

  // In DONE the arbiter sees only the served cpu so its pointer moves past it.
  assign arb_req = (state == ST_DONE) ? {cur, ~cur} : {req1, req0};

  assign other_found = cur ? found0 : found1;
  assign other_data  = cur ? pdata0 : pdata1;

  rr_arb2 u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (arb_req),
    .update (state == ST_DONE),
    .gnt    (arb_gnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cur   <= 1'b0;
      op    <= OP_NONE;
      addr  <= '0;
      data  <= '0;
      dsel  <= DSEL_NONE;
    end else begin
      case (state)
        ST_IDLE: if (|arb_gnt) begin
          cur   <= arb_gnt[1];
          op    <= arb_gnt[1] ? pick_op(rd_miss1, wr_miss1, inv1)
                              : pick_op(rd_miss0, wr_miss0, inv0);
          addr  <= arb_gnt[1] ? bico1 : bico0;
          data  <= '0;
          dsel  <= DSEL_NONE;
          state <= ST_SNOOP;
        end
        ST_SNOOP: state <= ST_RESP;
        ST_RESP: begin
          if (op == OP_INV) begin
            dsel  <= DSEL_NONE;
            state <= ST_DONE;
          end else if (other_found) begin
            data  <= other_data;
            dsel  <= DSEL_OTHER;
            state <= ST_DONE;
          end else begin
            state <= ST_MEM;
          end
        end
        ST_MEM: if (mem_rdy) begin
          dsel  <= DSEL_MEM;
          state <= ST_DONE;
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Outputs depend only on state and latched registers, never on live requests.
  assign snoop = (state == ST_SNOOP);
  assign done  = (state == ST_DONE);
  assign kill  = (op == OP_WR) || (op == OP_INV);

  assign boci      = snoop ? {op, addr} : 13'h0;
  assign search0   = snoop & cur;
  assign search1   = snoop & ~cur;
  assign inv_out0  = snoop & cur & kill;
  assign inv_out1  = snoop & ~cur & kill;
  assign grant0    = done & ~cur;
  assign grant1    = done & cur;
  assign datasel0  = grant0 ? dsel : DSEL_NONE;
  assign datasel1  = grant1 ? dsel : DSEL_NONE;
  assign odata0    = grant0 ? data : 16'h0;
  assign odata1    = grant1 ? data : 16'h0;
  assign mem_re    = (state == ST_MEM);
  assign busy      = (state != ST_IDLE);
  assign state_dbg = state;

endmodule

// File: tb/tb_coherence_bus.sv
// Self-checking bench for coherence_bus: transaction-level model of the
// arbitration and snoop/memory outcome, compared cycle by cycle.
module tb_coherence_bus;
  import common::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rd_miss0 = 1'b0, rd_miss1 = 1'b0;
  logic        wr_miss0 = 1'b0, wr_miss1 = 1'b0;
  logic        inv0 = 1'b0, inv1 = 1'b0;
  logic [10:0] bico0 = '0, bico1 = '0;
  logic        found0 = 1'b0, found1 = 1'b0;
  logic [15:0] pdata0 = '0, pdata1 = '0;
  logic        mem_rdy = 1'b0;
  logic [12:0] boci;
  logic        search0, search1, inv_out0, inv_out1, grant0, grant1;
  logic [1:0]  datasel0, datasel1;
  logic [15:0] odata0, odata1;
  logic        mem_re, busy;
  logic [2:0]  state_dbg;

  coherence_bus dut (
    .clk(clk), .rst_n(rst_n),
    .rd_miss0(rd_miss0), .rd_miss1(rd_miss1),
    .wr_miss0(wr_miss0), .wr_miss1(wr_miss1),
    .inv0(inv0), .inv1(inv1),
    .bico0(bico0), .bico1(bico1),
    .found0(found0), .found1(found1),
    .pdata0(pdata0), .pdata1(pdata1),
    .mem_rdy(mem_rdy),
    .boci(boci),
    .search0(search0), .search1(search1),
    .inv_out0(inv_out0), .inv_out1(inv_out1),
    .grant0(grant0), .grant1(grant1),
    .datasel0(datasel0), .datasel1(datasel1),
    .odata0(odata0), .odata1(odata1),
    .mem_re(mem_re), .busy(busy), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int          n_checks = 0;
  int          n_errors = 0;
  logic [18:0] exp_q[$];       // {cpu, datasel, odata} per expected grant
  bit          last_served = 1'b1;  // reset behaves as if cpu1 was served last

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return {7'h0, boci, search0, search1, inv_out0, inv_out1, grant0, grant1,
            datasel0, datasel1, odata0, odata1, mem_re, busy};
  endfunction

  // ---------------- driver tasks ----------------
  // Lower-priority miss lines are raised at random alongside the real op.
  task automatic set_req(input int c, input logic [1:0] op, input logic [10:0] a);
    logic rd, wr, iv;
    wr = (op == 2'b10);
    iv = (op == 2'b11) || (wr && $urandom_range(0, 1) == 1);
    rd = (op == 2'b01) || ((wr || op == 2'b11) && $urandom_range(0, 1) == 1);
    if (c == 0) begin rd_miss0 = rd; wr_miss0 = wr; inv0 = iv; bico0 = a; end
    else        begin rd_miss1 = rd; wr_miss1 = wr; inv1 = iv; bico1 = a; end
  endtask

  task automatic clr_req(input int c);
    if (c == 0) begin rd_miss0 = 0; wr_miss0 = 0; inv0 = 0; end
    else        begin rd_miss1 = 0; wr_miss1 = 0; inv1 = 0; end
  endtask

  // Follows one bus transaction of cpu c from SNOOP to the IDLE after grant.
  task automatic serve(input int c, input logic [1:0] op, input logic [10:0] a,
                       input bit fnd, input logic [15:0] pd, input int lat,
                       input int exp_snoop, output int done_cyc);
    int n, rdy_cyc;
    logic [1:0]  xd;
    logic [15:0] xo;
    logic [18:0] e;
    xd = (op == 2'b11) ? DSEL_NONE : (fnd ? DSEL_OTHER : DSEL_MEM);
    xo = (xd == DSEL_OTHER) ? pd : 16'h0;
    exp_q.push_back({c[0], xd, xo});
    rdy_cyc = 0;
    n = 0;
    do begin @(negedge clk); n++; end while (!(search0 || search1) && n < 50);
    done_cyc = cyc;
    if (!(search0 || search1)) begin
      check("snoop_timeout", 64'd0, 64'd1);
      return;
    end
    check("snoop_cycle", 64'(cyc), 64'(exp_snoop));
    check("boci", 64'(boci), 64'({op, a}));
    check("search_other", 64'(c == 0 ? search1 : search0), 64'd1);
    check("search_self", 64'(c == 0 ? search0 : search1), 64'd0);
    check("inv_out", 64'({inv_out1, inv_out0}),
          (op == 2'b10 || op == 2'b11) ? (c == 0 ? 64'd2 : 64'd1) : 64'd0);
    @(negedge clk);
    check("resp_quiet", 64'({boci, search0, search1, inv_out0, inv_out1, grant0, grant1, mem_re, busy}),
          64'd1);
    @(negedge clk);
    if (xd == DSEL_MEM) begin
      n = 0;
      while (mem_re && n < 60) begin
        n++;
        if (n == lat) begin mem_rdy = 1'b1; rdy_cyc = cyc; end
        @(negedge clk);
        mem_rdy = 1'b0;
      end
      check("mem_re_cycles", 64'(n), 64'(lat));
      check("mem_grant_lat", 64'(cyc), 64'(rdy_cyc + 1));
    end else begin
      check("done_cycle", 64'(cyc), 64'(exp_snoop + 2));
      check("no_mem_re", 64'(mem_re), 64'd0);
    end
    check("grant", 64'({grant1, grant0}), c == 0 ? 64'd1 : 64'd2);
    e = exp_q.pop_front();
    if (e[18] == 1'b0) begin
      check("datasel0", 64'(datasel0), 64'(e[17:16]));
      check("odata0", 64'(odata0), 64'(e[15:0]));
      check("other_quiet1", 64'({datasel1, odata1}), 64'd0);
    end else begin
      check("datasel1", 64'(datasel1), 64'(e[17:16]));
      check("odata1", 64'(odata1), 64'(e[15:0]));
      check("other_quiet0", 64'({datasel0, odata0}), 64'd0);
    end
    done_cyc = cyc;
    last_served = c[0];
    @(negedge clk);
    clr_req(c);
    check("idle_after_done", 64'({busy, grant0, grant1}), 64'd0);
  endtask

  // One or two simultaneous requests; the model decides the service order.
  task automatic scenario(input bit r0, input bit r1,
                          input logic [1:0] op0, input logic [1:0] op1,
                          input logic [10:0] a0, input logic [10:0] a1,
                          input bit f0, input bit f1,
                          input logic [15:0] p0, input logic [15:0] p1,
                          input int lat0, input int lat1);
    int t, d, first, second;
    @(negedge clk);
    found0 = f0; found1 = f1; pdata0 = p0; pdata1 = p1;
    if (r0) set_req(0, op0, a0);
    if (r1) set_req(1, op1, a1);
    t = cyc;
    if (r0 && r1) first = last_served ? 0 : 1;
    else          first = r0 ? 0 : 1;
    second = 1 - first;
    if (first == 0) serve(0, op0, a0, f1, p1, lat0, t + 1, d);
    else            serve(1, op1, a1, f0, p0, lat1, t + 1, d);
    if (r0 && r1) begin
      if (second == 0) serve(0, op0, a0, f1, p1, lat0, d + 2, d);
      else             serve(1, op1, a1, f0, p0, lat1, d + 2, d);
    end
    @(negedge clk);
    check("idle_quiet", all_outs(), 64'd0);
  endtask

  task automatic reset_in_mem();
    int n;
    @(negedge clk);
    found0 = 1'b0;
    set_req(1, 2'b01, 11'h2A3);
    n = 0;
    while (!mem_re && n < 20) begin @(negedge clk); n++; end
    check("mem_reached", 64'(mem_re), 64'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("reset_outs", all_outs(), 64'd0);
    check("reset_state", 64'(state_dbg), 64'd0);
    clr_req(1);
    last_served = 1'b1;
    @(negedge clk);
    check("reset_hold", all_outs(), 64'd0);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("post_reset_quiet", all_outs(), 64'd0);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int d;
    repeat (2) @(negedge clk);
    check("reset_outs_init", all_outs(), 64'd0);
    check("reset_state_init", 64'(state_dbg), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // tie after reset: cpu0 first, then cpu1's write invalidates cpu0
    scenario(1, 1, 2'b01, 2'b10, 11'h123, 11'h456, 1'b0, 1'b1, 16'h1111, 16'h2222, 2, 3);
    // cpu0 read miss hitting in cpu1
    scenario(1, 0, 2'b01, 2'b00, 11'h155, 11'h000, 1'b0, 1'b1, 16'h0000, 16'hBEEF, 1, 1);
    // cpu1 read miss served from memory after 4 cycles
    scenario(0, 1, 2'b00, 2'b01, 11'h000, 11'h3F0, 1'b0, 1'b0, 16'hAAAA, 16'h5555, 1, 4);
    // cpu0 invalidate
    scenario(1, 0, 2'b11, 2'b00, 11'h010, 11'h000, 1'b1, 1'b1, 16'h1234, 16'h4321, 1, 1);
    // boundary addresses and single-cycle memory
    scenario(1, 1, 2'b10, 2'b01, 11'h7FF, 11'h000, 1'b0, 1'b0, 16'hFFFF, 16'h0001, 1, 1);

    for (int i = 0; i < 24; i++) begin
      int mode;
      mode = $urandom_range(0, 2);
      scenario(mode != 1, mode != 0,
               2'($urandom_range(1, 3)), 2'($urandom_range(1, 3)),
               11'($urandom), 11'($urandom),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               16'($urandom), 16'($urandom),
               $urandom_range(1, 6), $urandom_range(1, 6));
    end

    reset_in_mem();
    scenario(0, 1, 2'b00, 2'b10, 11'h000, 11'h0AB, 1'b1, 1'b0, 16'hC0DE, 16'h0000, 1, 1);
    scenario(1, 1, 2'b11, 2'b11, 11'h001, 11'h002, 1'b0, 1'b0, 16'h0000, 16'h0000, 1, 1);

    d = exp_q.size();
    check("scoreboard_empty", 64'(d), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
